// File: rtl/ysyx_22040125_lsu.sv
// Load/store unit: one single-beat 64-bit memory access per request, with
// alignment/funct3 checking ahead of the bus and sign/zero extension of loads.
module ysyx_22040125_lsu #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned XLEN   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [63:0]       req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [2:0]        req_funct3,
    input  logic              req_store,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_data,
    output logic              resp_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [2:0]         off_q, off_d;
    logic [2:0]         f3_q, f3_d;
    logic               store_q, store_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;
    logic [7:0]         wmask_q, wmask_d;
    logic [XLEN-1:0]    rdata_q, rdata_d;
    logic               err_q, err_d;

    logic [2:0]         req_off;
    logic               misaligned;
    logic               bad_f3;
    logic [7:0]         req_mask;
    logic [XLEN-1:0]    rd_shift;
    logic [XLEN-1:0]    rd_ext;

    generate
        if (ADDR_W < 64) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^req_addr[63:ADDR_W];
        end
    endgenerate

    // Legality and byte-lane decode of the incoming request
    always_comb begin
        req_off    = req_addr[2:0];
        misaligned = 1'b0;
        req_mask   = 8'hFF;
        case (req_funct3[1:0])
            2'd0: req_mask = 8'h01 << req_off;
            2'd1: begin
                misaligned = req_off[0];
                req_mask   = 8'h03 << req_off;
            end
            2'd2: begin
                misaligned = |req_off[1:0];
                req_mask   = 8'h0F << req_off;
            end
            default: misaligned = |req_off;
        endcase
        bad_f3 = req_store ? req_funct3[2] : (req_funct3 == 3'b111);
    end

    always_comb begin
        rd_shift = mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  rd_ext = {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  rd_ext = {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  rd_ext = {{(XLEN-32){rd_shift[31]}}, rd_shift[31:0]};
            3'b100:  rd_ext = {{(XLEN-8){1'b0}}, rd_shift[7:0]};
            3'b101:  rd_ext = {{(XLEN-16){1'b0}}, rd_shift[15:0]};
            3'b110:  rd_ext = {{(XLEN-32){1'b0}}, rd_shift[31:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        off_d   = off_q;
        f3_d    = f3_q;
        store_d = store_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = {req_addr[ADDR_W-1:3], 3'b000};
                    off_d   = req_off;
                    f3_d    = req_funct3;
                    store_d = req_store;
                    wdata_d = req_wdata << {req_off, 3'b000};
                    wmask_d = req_mask;
                    rdata_d = '0;
                    err_d   = misaligned | bad_f3;
                    state_d = (misaligned | bad_f3) ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    rdata_d = store_q ? '0 : rd_ext;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            store_q <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            store_q <= store_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign mem_req_valid = (state_q == REQ);
    assign mem_wen       = (state_q == REQ) & store_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
    assign resp_valid    = (state_q == DONE);
    assign resp_data     = rdata_q;
    assign resp_err      = (state_q == DONE) & err_q;

endmodule

// File: tb/tb_ysyx_22040125_lsu.sv
// Scoreboard bench for the LSU: the driver pushes expected responses, a
// negedge monitor pops and compares data, error flag and latency.
module tb_ysyx_22040125_lsu;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned XLEN   = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [63:0]       req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [2:0]        req_funct3;
    logic              req_store;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [XLEN-1:0]   mem_wdata;
    logic [7:0]        mem_wmask;
    logic              mem_rsp_valid;
    logic [XLEN-1:0]   mem_rdata;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_data;
    logic              resp_err;

    ysyx_22040125_lsu #(.ADDR_W(ADDR_W), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_funct3(req_funct3), .req_store(req_store),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected resp_valid", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_data", resp_data, e.data);
                chk("resp_err", {63'd0, resp_err}, {63'd0, e.err});
                chk("latency", 64'(cyc - e.acc), 64'(e.lat));
            end
        end
    end

    task automatic op(input logic [63:0] addr, input logic [63:0] wdata, input logic [2:0] f3,
                      input logic st, input logic [63:0] rdata, input int rd, input int sd,
                      input logic [63:0] exp_data, input logic exp_err,
                      input logic [7:0] exp_mask, input logic [63:0] exp_wdata);
        exp_t e;
        logic [ADDR_W-1:0] ea;
        ea = addr[ADDR_W-1:0];
        ea[2:0] = 3'b000;
        chk("req_ready idle", {63'd0, req_ready}, 64'd1);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        req_store  = st;
        e.data = exp_data;
        e.err  = exp_err;
        e.acc  = cyc;
        e.lat  = exp_err ? 1 : 3 + rd + sd;
        @(posedge clk);
        sb.push_back(e);
        #1;
        req_valid = 1'b0;
        if (exp_err) begin
            repeat (3) begin
                chk("mem_req_valid on error", {63'd0, mem_req_valid}, 64'd0);
                @(posedge clk); #1;
            end
        end else begin
            for (int i = 0; i <= rd; i++) begin
                chk("mem_req_valid", {63'd0, mem_req_valid}, 64'd1);
                chk("mem_addr", 64'(mem_addr), 64'(ea));
                chk("mem_wen", {63'd0, mem_wen}, {63'd0, st});
                if (st) begin
                    chk("mem_wmask", {56'd0, mem_wmask}, {56'd0, exp_mask});
                    chk("mem_wdata", mem_wdata, exp_wdata);
                end
                if (i == rd) mem_req_ready = 1'b1;
                @(posedge clk); #1;
            end
            mem_req_ready = 1'b0;
            chk("mem_req_valid dropped", {63'd0, mem_req_valid}, 64'd0);
            for (int i = 0; i < sd; i++) begin
                @(posedge clk); #1;
            end
            mem_rsp_valid = 1'b1;
            mem_rdata     = rdata;
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
            mem_rdata     = '0;
        end
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            chk("response timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0; req_store = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rst mem_wen", {63'd0, mem_wen}, 64'd0);
        chk("rst mem_addr", 64'(mem_addr), 64'd0);
        chk("rst mem_wdata", mem_wdata, 64'd0);
        chk("rst mem_wmask", {56'd0, mem_wmask}, 64'd0);
        chk("rst resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst resp_data", resp_data, 64'd0);
        chk("rst resp_err", {63'd0, resp_err}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // loads: addr, wdata, f3, store, rdata, rd, sd, exp_data, err, mask, wdata
        op(64'h8000_0005, 64'd0, 3'b000, 1'b0, 64'h1122_3344_8566_7788, 0, 0, 64'h33, 1'b0, 8'h00, 64'd0);
        op(64'h8000_0005, 64'd0, 3'b100, 1'b0, 64'h1122_3344_8566_7788, 0, 0, 64'h33, 1'b0, 8'h00, 64'd0);
        op(64'h8000_0003, 64'd0, 3'b000, 1'b0, 64'h1122_3344_8566_7788, 0, 0, 64'hFFFF_FFFF_FFFF_FF85, 1'b0, 8'h00, 64'd0);
        op(64'h8000_0003, 64'd0, 3'b100, 1'b0, 64'h1122_3344_8566_7788, 0, 0, 64'h85, 1'b0, 8'h00, 64'd0);
        op(64'h8000_0002, 64'd0, 3'b001, 1'b0, 64'h1122_3344_8566_7788, 0, 0, 64'hFFFF_FFFF_FFFF_8566, 1'b0, 8'h00, 64'd0);
        op(64'h8000_0002, 64'd0, 3'b101, 1'b0, 64'h1122_3344_8566_7788, 0, 0, 64'h8566, 1'b0, 8'h00, 64'd0);
        op(64'h8000_0004, 64'd0, 3'b110, 1'b0, 64'h8765_4321_0000_0000, 0, 0, 64'h0000_0000_8765_4321, 1'b0, 8'h00, 64'd0);
        op(64'h8000_0004, 64'd0, 3'b010, 1'b0, 64'h8765_4321_0000_0000, 0, 0, 64'hFFFF_FFFF_8765_4321, 1'b0, 8'h00, 64'd0);
        op(64'h8000_0008, 64'd0, 3'b011, 1'b0, 64'h1122_3344_8566_7788, 0, 0, 64'h1122_3344_8566_7788, 1'b0, 8'h00, 64'd0);

        // stores
        op(64'h8000_0006, 64'hABCD, 3'b001, 1'b1, 64'd0, 0, 0, 64'd0, 1'b0, 8'hC0, 64'hABCD_0000_0000_0000);
        op(64'h8000_0001, 64'hDEAD_BEEF_CAFE_F012, 3'b000, 1'b1, 64'd0, 0, 0, 64'd0, 1'b0, 8'h02, 64'hADBE_EFCA_FEF0_1200);
        op(64'h8000_0004, 64'h1122_3344, 3'b010, 1'b1, 64'd0, 0, 0, 64'd0, 1'b0, 8'hF0, 64'h1122_3344_0000_0000);
        op(64'h8000_0000, 64'h0123_4567_89AB_CDEF, 3'b011, 1'b1, 64'd0, 0, 0, 64'd0, 1'b0, 8'hFF, 64'h0123_4567_89AB_CDEF);

        // error responses
        op(64'h8000_0004, 64'd0, 3'b011, 1'b0, 64'd0, 0, 0, 64'd0, 1'b1, 8'h00, 64'd0);
        op(64'h8000_0000, 64'h55, 3'b100, 1'b1, 64'd0, 0, 0, 64'd0, 1'b1, 8'h00, 64'd0);
        op(64'h8000_0001, 64'd0, 3'b001, 1'b0, 64'd0, 0, 0, 64'd0, 1'b1, 8'h00, 64'd0);
        op(64'h8000_0000, 64'd0, 3'b111, 1'b0, 64'd0, 0, 0, 64'd0, 1'b1, 8'h00, 64'd0);
        op(64'h8000_0002, 64'h77, 3'b010, 1'b1, 64'd0, 0, 0, 64'd0, 1'b1, 8'h00, 64'd0);

        // memory stalls: 5 cycles of ready low, 2 extra response wait cycles
        op(64'h8000_0000, 64'd0, 3'b010, 1'b0, 64'hFFFF_FFFF_7FFF_FFFF, 5, 2, 64'h7FFF_FFFF, 1'b0, 8'h00, 64'd0);
        op(64'h8000_0002, 64'h9876, 3'b001, 1'b1, 64'd0, 2, 1, 64'd0, 1'b0, 8'h0C, 64'h0000_0000_9876_0000);

        // reset while waiting for the response drops the operation
        req_valid = 1'b1; req_addr = 64'h8000_0010; req_funct3 = 3'b011; req_store = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid-rst req_ready", {63'd0, req_ready}, 64'd1);
        chk("mid-rst mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("mid-rst resp_valid", {63'd0, resp_valid}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        mem_rdata = '0;
        repeat (3) begin
            chk("post-rst resp_valid", {63'd0, resp_valid}, 64'd0);
            chk("post-rst req_ready", {63'd0, req_ready}, 64'd1);
            @(posedge clk); #1;
        end
        op(64'h8000_0010, 64'd0, 3'b011, 1'b0, 64'hCAFE_BABE_1234_5678, 0, 0, 64'hCAFE_BABE_1234_5678, 1'b0, 8'h00, 64'd0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
